bcl_serial_sub_19: RTL and testbench



---
 rtl/bcl_serial_sub_19_pkg.sv | 29 ++
 rtl/bcl_serial_sub_19_if.sv | 24 ++
 rtl/bcl_serial_sub_19_block.sv | 40 ++++
 rtl/bcl_serial_sub_19.sv | 124 ++++++++++++
 tb/tb_bcl_serial_sub_19.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bcl_serial_sub_19_pkg.sv
// Shared constants, FSM state type and block partition helper for the
// block-serial 19-bit subtractor.
package bcl_sub_pkg;

  localparam int WIDTH      = 19;
  localparam int BLK        = 4;
  localparam int NBLK       = 5;
  localparam int LAST_BLK_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic [4:0] lo;
    logic [2:0] lanes;
  } blk_info_t;

  // Blocks are 4 bits wide LSB first; the top block only has 3 live lanes.
  function automatic blk_info_t block_info(input logic [2:0] k);
    blk_info_t info;
    info.lo    = {k, 2'b00};
    info.lanes = (k == 3'(NBLK - 1)) ? 3'(LAST_BLK_W) : 3'(BLK);
    return info;
  endfunction

endpackage

// File: rtl/bcl_serial_sub_19_if.sv
// Operand/result handshake bundle for bcl_serial_sub_19.
interface bcl_serial_sub_19_if;
  import bcl_sub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   d;
  logic             busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, d, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, d, busy
  );

endinterface

// File: rtl/bcl_serial_sub_19_block.sv
// One 4-bit carry look-ahead slice of x + ~y; cout is tapped at the
// requested lane so a narrower top block reports its own carry.
module bcl_sub_block (
  input  logic [3:0] a,
  input  logic [3:0] b_n,
  input  logic       cin,
  input  logic [2:0] lanes,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b_n;
  assign p = a ^ b_n;

  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
  end

  always_comb begin
    case (lanes)
      3'd0:    cout = c[0];
      3'd1:    cout = c[1];
      3'd2:    cout = c[2];
      3'd3:    cout = c[3];
      default: cout = c[4];
    endcase
  end

endmodule

// File: rtl/bcl_serial_sub_19.sv
// Block-serial subtractor: d = x - y (20-bit two's complement), one
// carry look-ahead block per clock behind a valid/ready handshake.
module bcl_serial_sub_19
  import bcl_sub_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bcl_serial_sub_19_if.slave  bus
);

  state_t           state;
  logic [2:0]       blk;
  logic             carry;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_n_reg;
  logic [WIDTH:0]   d_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  blk_info_t        info;
  logic [3:0]       a;
  logic [3:0]       b_n;
  logic [3:0]       sum;
  logic             cout;
  logic             last_blk;
  logic [WIDTH:0]   mask;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   d_next;

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.d         = d_reg;
  assign bus.busy      = busy_reg;

  assign info     = block_info(blk);
  assign last_blk = (blk == 3'(NBLK - 1));

  always_comb begin
    a   = '0;
    b_n = '0;
    case (blk)
      3'd0: begin a = x_reg[3:0];   b_n = y_n_reg[3:0];   end
      3'd1: begin a = x_reg[7:4];   b_n = y_n_reg[7:4];   end
      3'd2: begin a = x_reg[11:8];  b_n = y_n_reg[11:8];  end
      3'd3: begin a = x_reg[15:12]; b_n = y_n_reg[15:12]; end
      3'd4: begin a = {1'b0, x_reg[18:16]}; b_n = {1'b1, y_n_reg[18:16]}; end
      default: begin a = '0; b_n = '0; end
    endcase
  end

  bcl_sub_block u_block (
    .a     (a),
    .b_n   (b_n),
    .cin   (carry),
    .lanes (info.lanes),
    .sum   (sum),
    .cout  (cout)
  );

  // The top block's 4th sum lane is padding; d[19] is the inverted carry out.
  always_comb begin
    sum_ext = {{(WIDTH + 1 - BLK){1'b0}}, sum};
    mask    = {{(WIDTH + 1 - BLK){1'b0}}, {BLK{1'b1}}} << info.lo;
    d_next  = (d_reg & ~mask) | (sum_ext << info.lo);
    if (last_blk) begin
      d_next[WIDTH] = ~cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      blk           <= '0;
      carry         <= 1'b0;
      x_reg         <= '0;
      y_n_reg       <= '0;
      d_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg        <= bus.x;
            y_n_reg      <= ~bus.y;
            carry        <= 1'b1;
            blk          <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          d_reg <= d_next;
          carry <= cout;
          if (last_blk) begin
            blk           <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            blk <= blk + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcl_serial_sub_19.sv
// Directed and random checks of bcl_serial_sub_19 against hand-computed
// and bench-computed differences.
module tb_bcl_serial_sub_19;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bcl_serial_sub_19_if bus ();

  bcl_serial_sub_19 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then presents one operand pair for a single edge.
  task automatic applyStimulus(input logic [18:0] xv, input logic [18:0] yv);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    checkOutput("in_ready", bus.in_ready, 1);
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [18:0] xv,
                       input logic [18:0] yv, input logic [19:0] exp);
    int n = 0;
    applyStimulus(xv, yv);
    checkOutput("in_ready_low", bus.in_ready, 0);
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
      if (n == 1) checkOutput("busy", bus.busy, 1);
    end
    checkOutput("out_valid", bus.out_valid, 1);
    checkOutput("latency", n, 5);
    checkOutput(tag, bus.d, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("out_valid_clr", bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int seen;
    int nacc;
    int acc[3];
    logic [18:0] xv, yv;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_d", bus.d, 0);
    rst_n = 1'b1;

    runOp("d_5_3", 19'h00005, 19'h00003, 20'h00002);
    runOp("d_3_5", 19'h00003, 19'h00005, 20'hFFFFE);
    runOp("d_max_max", 19'h7FFFF, 19'h7FFFF, 20'h00000);
    runOp("d_0_max", 19'h00000, 19'h7FFFF, 20'h80001);
    runOp("d_ripple", 19'h10000, 19'h00001, 20'h0FFFF);

    // Result held while the consumer stalls; new operands must be ignored.
    applyStimulus(19'h00005, 19'h00003);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput("stall_valid", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      bus.x        = 19'h7FFFF;
      bus.y        = 19'h00000;
      bus.in_valid = (i % 2 == 0);
      step();
      checkOutput("stall_d", bus.d, 20'h00002);
      checkOutput("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("stall_release", bus.out_valid, 0);
    checkOutput("stall_ready_back", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= int'(bus.out_valid);
    end
    checkOutput("no_ghost_result", seen, 0);
    runOp("after_stall", 19'h00003, 19'h00005, 20'hFFFFE);

    // Reset while block 2 is next to be processed.
    applyStimulus(19'h7FFFF, 19'h00000);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midrst_valid", bus.out_valid, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= int'(bus.out_valid);
    end
    checkOutput("midrst_no_result", seen, 0);
    runOp("after_reset", 19'h12345, 19'h02345, 20'h10000);

    // Back-to-back with the consumer always ready.
    nacc = 0;
    acc  = '{-100, -100, -100};
    bus.x         = 19'h00005;
    bus.y         = 19'h00003;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.in_ready && nacc < 3) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (bus.out_valid) checkOutput("b2b_d", bus.d, 20'h00002);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.out_ready = 1'b0;
    checkOutput("b2b_accepts", nacc, 3);
    checkOutput("b2b_gap1", acc[1] - acc[0], 7);
    checkOutput("b2b_gap2", acc[2] - acc[1], 7);

    for (int i = 0; i < 1000; i++) begin
      xv = 19'($urandom);
      yv = 19'($urandom);
      runOp("rand_d", xv, yv, 20'({1'b0, xv} - {1'b0, yv}));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
